// File: rtl/alu_div32.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned,
// with a start/busy/done handshake and registered quotient/remainder outputs.
module alu_div32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_nb;
  logic [WIDTH:0]   g;
  logic [WIDTH:0]   p;
  logic [WIDTH+1:0] c;
  logic [WIDTH:0]   diff;
  logic             co;

  always_comb begin
    dvd_neg = signed_op & dividend[WIDTH-1];
    dvs_neg = signed_op & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
  end

  // Trial subtract a - b = a + ~b + 1 on the adder's generate/propagate chain;
  // carry-out set means the shifted remainder is >= the divisor.
  always_comb begin
    trial_a  = {rem[WIDTH-1:0], q[WIDTH-1]};
    trial_nb = ~{1'b0, dvs};
    g        = trial_a & trial_nb;
    p        = trial_a ^ trial_nb;
    c        = '0;
    c[0]     = 1'b1;
    diff     = '0;
    for (int unsigned i = 0; i <= WIDTH; i++) begin
      diff[i]  = p[i] ^ c[i];
      c[i + 1] = g[i] | (p[i] & c[i]);
    end
    co = c[WIDTH + 1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
            dvs   <= dvs_mag;
            rem   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            if (divisor == '0) begin
              // Keep the raw dividend so it can be returned as the remainder.
              dz    <= 1'b1;
              q     <= dividend;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              q     <= dvd_mag;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= co ? diff : trial_a;
          q   <= {q[WIDTH-2:0], co};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          div_by_zero <= dz;
          if (dz) begin
            quotient  <= '1;
            remainder <= q;
          end else begin
            quotient  <= neg_q ? (~q + 1'b1) : q;
            remainder <= neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div32.sv
// Directed-vector bench for alu_div32: latency, handshake, sign rules,
// divide-by-zero, ignored start while busy and asynchronous reset abort.
module tb_alu_div32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  alu_div32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive operands before a rising edge, hold start for that edge only, then
  // scramble the operand inputs to show they are not re-sampled.
  task automatic launch(input logic sop, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = 32'h5A5A_1234;
    divisor   = 32'h0000_0003;
    signed_op = ~sop;
  endtask

  // Called #1 after the capture edge; returns edges until done and busy cycles.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic sop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int elat);
    int lat, bc;
    launch(sop, a, b);
    wait_done(lat, bc);
    check({tag, ".lat"}, 32'(lat), 32'(elat));
    check({tag, ".busy_cycles"}, 32'(bc), 32'(elat));
    check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    check({tag, ".dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat, bc, extra;
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #22;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.q", quotient, 32'd0);
    check("rst.r", remainder, 32'd0);
    check("rst.dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("u100_7",   1'b0, 32'd100,       32'd7,          32'd14,        32'd2,         1'b0, 33);
    run_div("s-7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_div("s7_-2",    1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0, 33);
    run_div("u5_0",     1'b0, 32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5,         1'b1, 1);
    run_div("s-5_0",    1'b1, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
    run_div("u9_3",     1'b0, 32'd9,         32'd3,          32'd3,         32'd0,         1'b0, 33);
    run_div("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0, 33);
    run_div("umax_1",   1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,         1'b0, 33);
    run_div("u_big",    1'b0, 32'hFFFF_FFFF, 32'h8000_0000,  32'd1,         32'h7FFF_FFFF, 1'b0, 33);
    run_div("s-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        32'hFFFF_FFFE, 1'b0, 33);

    // Second start at T+5 while busy must be ignored.
    launch(1'b0, 32'd1000, 32'd9);
    repeat (4) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    check("ign.lat", 32'(lat + 5), 32'd33);
    check("ign.q", quotient, 32'd111);
    check("ign.r", remainder, 32'd1);
    extra = 0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("ign.extra_done", 32'(extra), 32'd0);

    // Reset mid-RUN clears everything asynchronously.
    launch(1'b0, 32'd500, 32'd7);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.busy", {31'd0, busy}, 32'd0);
    check("arst.done", {31'd0, done}, 32'd0);
    check("arst.q", quotient, 32'd0);
    check("arst.r", remainder, 32'd0);
    check("arst.dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_div("post_rst", 1'b0, 32'd500, 32'd7, 32'd71, 32'd3, 1'b0, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
